// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit for the EX stage, owning HI/LO.
// Results are computed from the operands at the accept edge and held until the
// busy countdown expires, when they are committed to HI/LO.
// Optional feature: define MDU_MADD_EN to make MADD (7) and MSUB (8) legal;
// otherwise those codes behave as NONE.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDUop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
`endif

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] res_q, res_d;
  logic        upd_q, upd_d;

  logic [63:0] prod_s, prod_u;
  logic        b_zero;
  logic [31:0] b_safe, a_mag, b_mag, q_mag, r_mag;
  logic [31:0] div_q_s, div_r_s, div_q_u, div_r_u;

  // Products are taken modulo 2^64; sign-extending to 64 bits gives the signed form.
  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide via magnitudes: quotient truncates toward zero, remainder
  // follows A. 0x80000000 / -1 falls out as 0x80000000 rem 0 without a special case.
  // A zero divisor is replaced by 1 so no X is produced; that result is discarded.
  assign b_zero  = (B == 32'd0);
  assign b_safe  = b_zero ? 32'd1 : B;
  assign a_mag   = A[31] ? -A : A;
  assign b_mag   = b_safe[31] ? -b_safe : b_safe;
  assign q_mag   = a_mag / b_mag;
  assign r_mag   = a_mag % b_mag;
  assign div_q_s = (A[31] ^ b_safe[31]) ? -q_mag : q_mag;
  assign div_r_s = A[31] ? -r_mag : r_mag;
  assign div_q_u = A / b_safe;
  assign div_r_u = A % b_safe;

  assign busy = (state_q == S_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

  // Accept/countdown sequencing and HI/LO next-value selection.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    upd_d   = upd_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (MDUop)
            OP_MULT: begin
              res_d = prod_s; upd_d = 1'b1; count_d = MULT_N; state_d = S_RUN;
            end
            OP_MULTU: begin
              res_d = prod_u; upd_d = 1'b1; count_d = MULT_N; state_d = S_RUN;
            end
            OP_DIV: begin
              res_d = {div_r_s, div_q_s}; upd_d = !b_zero; count_d = DIV_N; state_d = S_RUN;
            end
            OP_DIVU: begin
              res_d = {div_r_u, div_q_u}; upd_d = !b_zero; count_d = DIV_N; state_d = S_RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
`ifdef MDU_MADD_EN
            OP_MADD: begin
              res_d = {hi_q, lo_q} + prod_s; upd_d = 1'b1; count_d = MULT_N; state_d = S_RUN;
            end
            OP_MSUB: begin
              res_d = {hi_q, lo_q} - prod_s; upd_d = 1'b1; count_d = MULT_N; state_d = S_RUN;
            end
`endif
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (count_q == 5'd1) begin
          if (upd_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
          upd_d   = 1'b0;
          count_d = 5'd0;
          state_d = S_IDLE;
        end else begin
          count_d = count_q - 5'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and architectural HI/LO registers; reset aborts any operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      res_q   <= 64'd0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      upd_q   <= upd_d;
    end
  end

endmodule
